// File: rtl/apb_coeff_bank_regfile.sv
// APB register file for DFE coefficient banks: shadow/active double buffering,
// control register, sticky W1C status with IRQ, one-wait-state handshake.
module apb_coeff_bank_regfile #(
   parameter int ADDR_WIDTH  = 9,
   parameter int DATA_WIDTH  = 32,
   parameter int COEFF_WIDTH = 20,
   parameter int NUM_BANKS   = 4,
   parameter int BANK_DEPTH  = 72,
   parameter int NUM_CH      = 6,
   parameter int SEL_W       = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   output logic                    PREADY,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PSLVERR,
   output logic [NUM_BANKS*BANK_DEPTH*COEFF_WIDTH-1:0] COEFF_OUT,
   output logic [NUM_BANKS-1:0]    BANK_VLD,
   output logic [NUM_CH-1:0]       CTRL_EN,
   output logic [SEL_W-1:0]        OUT_SEL,
   input  logic [2*NUM_CH-1:0]     STATUS_IN,
   output logic                    IRQ
);

   localparam int B  = NUM_BANKS * BANK_DEPTH;
   localparam int BW = BANK_DEPTH * COEFF_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(B);
   localparam logic [ADDR_WIDTH-1:0] A_COMMIT = ADDR_WIDTH'(B + 1);
   localparam logic [ADDR_WIDTH-1:0] A_STAT   = ADDR_WIDTH'(B + 2);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t                  state_q;
   logic [B*COEFF_WIDTH-1:0] shadow_q;
   logic [B*COEFF_WIDTH-1:0] active_q;
   logic                    pready_q;
   logic                    pslverr_q;
   logic [DATA_WIDTH-1:0]   prdata_q;
   logic [NUM_BANKS-1:0]    bank_vld_q;
   logic [NUM_BANKS-1:0]    loaded_q;
   logic [NUM_CH-1:0]       ctrl_en_q;
   logic [SEL_W-1:0]        out_sel_q;
   logic [2*NUM_CH-1:0]     status_q;
   logic                    irq_q;

   logic                    fire;
   logic                    wr_en;
   logic                    is_coef;
   logic                    is_ctrl;
   logic                    is_commit;
   logic                    is_stat;
   logic                    illegal;
   logic [COEFF_WIDTH-1:0]  coef_rd;
   logic [DATA_WIDTH-1:0]   rdata_d;
   logic [NUM_BANKS-1:0]    commit_d;
   logic [2*NUM_CH-1:0]     clr_d;

   function automatic logic [DATA_WIDTH-1:0] sext(input logic [COEFF_WIDTH-1:0] c);
      logic [DATA_WIDTH-1:0] r;
      r = {DATA_WIDTH{c[COEFF_WIDTH-1]}};
      r[COEFF_WIDTH-1:0] = c;
      return r;
   endfunction

   assign fire      = (state_q == ACCESS) && PSEL && PENABLE;
   assign is_coef   = PADDR < A_CTRL;
   assign is_ctrl   = PADDR == A_CTRL;
   assign is_commit = PADDR == A_COMMIT;
   assign is_stat   = PADDR == A_STAT;
   assign illegal   = !(is_coef || is_ctrl || is_commit || is_stat);
   assign wr_en     = fire && PWRITE && !illegal;
   assign coef_rd   = shadow_q[int'(PADDR)*COEFF_WIDTH +: COEFF_WIDTH];
   assign commit_d  = (wr_en && is_commit) ? PWDATA[NUM_BANKS-1:0] : '0;
   assign clr_d     = (wr_en && is_stat) ? PWDATA[2*NUM_CH-1:0] : '0;

   always_comb begin
      rdata_d = '0;
      unique case (1'b1)
         is_coef:   rdata_d = sext(coef_rd);
         is_ctrl:   rdata_d = DATA_WIDTH'({out_sel_q, ctrl_en_q});
         is_commit: rdata_d = DATA_WIDTH'(loaded_q);
         is_stat:   rdata_d = DATA_WIDTH'(status_q);
         default:   rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               pready_q  <= 1'b0;
               pslverr_q <= 1'b0;
               prdata_q  <= '0;
               if (PSEL && !PENABLE) state_q <= ACCESS;
            end
            ACCESS: begin
               // a master that drops PSEL mid-transfer gets no completion
               if (!PSEL) begin
                  state_q <= IDLE;
               end else if (PENABLE) begin
                  state_q   <= DONE;
                  pready_q  <= 1'b1;
                  pslverr_q <= illegal;
                  prdata_q  <= (PWRITE || illegal) ? '0 : rdata_d;
               end
            end
            DONE: begin
               state_q   <= IDLE;
               pready_q  <= 1'b0;
               pslverr_q <= 1'b0;
               prdata_q  <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q   <= '0;
         active_q   <= '0;
         bank_vld_q <= '0;
         loaded_q   <= '0;
         ctrl_en_q  <= '0;
         out_sel_q  <= '0;
         status_q   <= '0;
         irq_q      <= 1'b0;
      end else begin
         bank_vld_q <= commit_d;
         loaded_q   <= loaded_q | commit_d;
         status_q   <= (status_q & ~clr_d) | STATUS_IN;
         irq_q      <= |status_q;
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (commit_d[b]) active_q[b*BW +: BW] <= shadow_q[b*BW +: BW];
         end
         if (wr_en && is_coef)
            shadow_q[int'(PADDR)*COEFF_WIDTH +: COEFF_WIDTH] <= PWDATA[COEFF_WIDTH-1:0];
         if (wr_en && is_ctrl) begin
            ctrl_en_q <= PWDATA[NUM_CH-1:0];
            out_sel_q <= PWDATA[NUM_CH+SEL_W-1:NUM_CH];
         end
      end
   end

   assign PREADY    = pready_q;
   assign PRDATA    = prdata_q;
   assign PSLVERR   = pslverr_q;
   assign COEFF_OUT = active_q;
   assign BANK_VLD  = bank_vld_q;
   assign CTRL_EN   = ctrl_en_q;
   assign OUT_SEL   = out_sel_q;
   assign IRQ       = irq_q;

endmodule

// File: tb/tb_apb_coeff_bank_regfile.sv
// Scenario bench for apb_coeff_bank_regfile: APB transfers go through an
// expectation queue, register side effects checked against a small model.
module tb_apb_coeff_bank_regfile;

   localparam int AW = 9;
   localparam int DW = 32;
   localparam int CW = 20;
   localparam int NB = 4;
   localparam int BD = 72;
   localparam int NC = 6;
   localparam int SW = 2;
   localparam int B  = NB * BD;
   localparam logic [AW-1:0] A_CTRL   = 9'd288;
   localparam logic [AW-1:0] A_COMMIT = 9'd289;
   localparam logic [AW-1:0] A_STAT   = 9'd290;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic PSEL = 1'b0;
   logic PENABLE = 1'b0;
   logic PWRITE = 1'b0;
   logic [AW-1:0] PADDR = '0;
   logic [DW-1:0] PWDATA = '0;
   logic PREADY;
   logic [DW-1:0] PRDATA;
   logic PSLVERR;
   logic [B*CW-1:0] COEFF_OUT;
   logic [NB-1:0] BANK_VLD;
   logic [NC-1:0] CTRL_EN;
   logic [SW-1:0] OUT_SEL;
   logic [2*NC-1:0] STATUS_IN = '0;
   logic IRQ;

   apb_coeff_bank_regfile #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COEFF_WIDTH(CW),
      .NUM_BANKS(NB), .BANK_DEPTH(BD), .NUM_CH(NC), .SEL_W(SW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA),
      .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
      .COEFF_OUT(COEFF_OUT), .BANK_VLD(BANK_VLD),
      .CTRL_EN(CTRL_EN), .OUT_SEL(OUT_SEL),
      .STATUS_IN(STATUS_IN), .IRQ(IRQ)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] rd;
      logic          err;
      logic          chk;
   } exp_t;

   exp_t sb[$];
   int total = 0;
   int bad = 0;
   logic [NB-1:0] bv_at_ready;
   logic [CW-1:0] shadow_m [B];
   logic [CW-1:0] active_m [B];

   function automatic logic [B*CW-1:0] model_coeff();
      logic [B*CW-1:0] v;
      for (int i = 0; i < B; i++) v[i*CW +: CW] = active_m[i];
      return v;
   endfunction

   function automatic logic [DW-1:0] sx(input logic [CW-1:0] c);
      return {{(DW-CW){c[CW-1]}}, c};
   endfunction

   // Caller is at #1 after a rising edge; returns at #1 after the edge
   // that retires the transfer, with the bus idle.
   task automatic xfer(input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                       input logic exp_err, input logic [2*NC-1:0] sin);
      exp_t e;
      int n;
      e.rd = exp_rd;
      e.err = exp_err;
      e.chk = !wr || exp_err;
      sb.push_back(e);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
      @(posedge clk); #1;
      total++;
      if (PREADY !== 1'b0) begin
         bad++;
         $display("FAIL setup_ready addr=%0d got=%b want=0", a, PREADY);
      end
      PENABLE = 1'b1;
      STATUS_IN = sin;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (PREADY !== 1'b1 && n < 4);
      STATUS_IN = '0;
      bv_at_ready = BANK_VLD;
      e = sb.pop_front();
      total++;
      if (PREADY !== 1'b1 || n != 1) begin
         bad++;
         $display("FAIL ready_latency addr=%0d got=%0d cycles want=1", a, n);
      end else begin
         total++;
         if (PSLVERR !== e.err) begin
            bad++;
            $display("FAIL pslverr addr=%0d got=%b want=%b", a, PSLVERR, e.err);
         end
         if (e.chk) begin
            total++;
            if (PRDATA !== e.rd) begin
               bad++;
               $display("FAIL prdata addr=%0d got=%h want=%h", a, PRDATA, e.rd);
            end
         end
      end
      @(posedge clk); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      total++;
      if (PREADY !== 1'b0) begin
         bad++;
         $display("FAIL ready_width addr=%0d got=%b want=0", a, PREADY);
      end
   endtask

   task automatic wr_coeff(input logic [AW-1:0] a, input logic [DW-1:0] d);
      xfer(1'b1, a, d, '0, 1'b0, '0);
      shadow_m[a] = d[CW-1:0];
   endtask

   task automatic commit(input logic [NB-1:0] m);
      xfer(1'b1, A_COMMIT, DW'(m), '0, 1'b0, '0);
      for (int b = 0; b < NB; b++)
         if (m[b]) for (int k = 0; k < BD; k++) active_m[b*BD+k] = shadow_m[b*BD+k];
   endtask

   task automatic clear_model();
      for (int i = 0; i < B; i++) begin
         shadow_m[i] = '0;
         active_m[i] = '0;
      end
   endtask

   task automatic test_reset();
      clear_model();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({PREADY, PSLVERR, PRDATA, BANK_VLD, CTRL_EN, OUT_SEL, IRQ} !== '0) begin
         bad++;
         $display("FAIL reset_ctl got rdy=%b err=%b rd=%h vld=%b en=%b sel=%b irq=%b want all 0",
                  PREADY, PSLVERR, PRDATA, BANK_VLD, CTRL_EN, OUT_SEL, IRQ);
      end
      total++;
      if (COEFF_OUT !== '0) begin
         bad++;
         $display("FAIL reset_coeff got nonzero want 0");
      end
   endtask

   task automatic test_back_to_back();
      wr_coeff(9'd5, 32'h000F_FFFF);
      xfer(1'b0, 9'd5, '0, 32'hFFFF_FFFF, 1'b0, '0);
      wr_coeff(9'd287, 32'hABC7_FFFF);
      xfer(1'b0, 9'd287, '0, 32'h0007_FFFF, 1'b0, '0);
      total++;
      if (COEFF_OUT[5*CW +: CW] !== '0) begin
         bad++;
         $display("FAIL shadow_leak got=%h want=0", COEFF_OUT[5*CW +: CW]);
      end
   endtask

   task automatic test_commit();
      wr_coeff(9'd144, 32'h0001_2345);
      wr_coeff(9'd75, 32'h0000_0ABC);
      commit(4'b0101);
      total++;
      if (bv_at_ready !== 4'b0101) begin
         bad++;
         $display("FAIL bank_vld got=%b want=0101", bv_at_ready);
      end
      total++;
      if (BANK_VLD !== 4'b0000) begin
         bad++;
         $display("FAIL bank_vld_clear got=%b want=0000", BANK_VLD);
      end
      total++;
      if (COEFF_OUT[5*CW +: CW] !== 20'hFFFFF || COEFF_OUT[144*CW +: CW] !== 20'h12345 ||
          COEFF_OUT[75*CW +: CW] !== '0 || COEFF_OUT[287*CW +: CW] !== '0) begin
         bad++;
         $display("FAIL commit_words got w5=%h w144=%h w75=%h w287=%h want fffff 12345 0 0",
                  COEFF_OUT[5*CW +: CW], COEFF_OUT[144*CW +: CW],
                  COEFF_OUT[75*CW +: CW], COEFF_OUT[287*CW +: CW]);
      end
      total++;
      if (COEFF_OUT !== model_coeff()) begin
         bad++;
         $display("FAIL commit_banks got differs from model");
      end
      xfer(1'b0, A_COMMIT, '0, 32'h5, 1'b0, '0);
      xfer(1'b0, 9'd144, '0, 32'h0001_2345, 1'b0, '0);
      commit(4'b0000);
      total++;
      if (bv_at_ready !== 4'b0000 || COEFF_OUT !== model_coeff()) begin
         bad++;
         $display("FAIL commit_zero got vld=%b want 0000 and unchanged banks", bv_at_ready);
      end
      commit(4'b1010);
      total++;
      if (bv_at_ready !== 4'b1010 || COEFF_OUT !== model_coeff()) begin
         bad++;
         $display("FAIL commit_1010 got vld=%b want 1010 and banks=model", bv_at_ready);
      end
      xfer(1'b0, A_COMMIT, '0, 32'hF, 1'b0, '0);
   endtask

   task automatic test_ctrl();
      xfer(1'b1, A_CTRL, 32'hFFFF_FFFF, '0, 1'b0, '0);
      xfer(1'b0, A_CTRL, '0, 32'h0000_00FF, 1'b0, '0);
      xfer(1'b1, A_CTRL, 32'h0000_00AA, '0, 1'b0, '0);
      total++;
      if (CTRL_EN !== 6'b101010 || OUT_SEL !== 2'b10) begin
         bad++;
         $display("FAIL ctrl_out got en=%b sel=%b want 101010 10", CTRL_EN, OUT_SEL);
      end
      xfer(1'b0, A_CTRL, '0, 32'h0000_00AA, 1'b0, '0);
   endtask

   task automatic test_status();
      STATUS_IN = 12'h008;
      @(posedge clk); #1;
      STATUS_IN = '0;
      total++;
      if (IRQ !== 1'b0) begin
         bad++;
         $display("FAIL irq_latency got=%b want=0", IRQ);
      end
      @(posedge clk); #1;
      total++;
      if (IRQ !== 1'b1) begin
         bad++;
         $display("FAIL irq_set got=%b want=1", IRQ);
      end
      xfer(1'b0, A_STAT, '0, 32'h8, 1'b0, '0);
      xfer(1'b1, A_STAT, 32'h8, '0, 1'b0, 12'h008);
      xfer(1'b0, A_STAT, '0, 32'h8, 1'b0, '0);
      xfer(1'b1, A_STAT, 32'hFFFF_F008, '0, 1'b0, '0);
      total++;
      if (IRQ !== 1'b0) begin
         bad++;
         $display("FAIL irq_clear got=%b want=0", IRQ);
      end
      xfer(1'b0, A_STAT, '0, 32'h0, 1'b0, '0);
      xfer(1'b0, A_STAT, '0, 32'h0, 1'b0, 12'h801);
      xfer(1'b1, A_STAT, 32'h1, '0, 1'b0, '0);
      xfer(1'b0, A_STAT, '0, 32'h800, 1'b0, '0);
      xfer(1'b1, A_STAT, 32'h800, '0, 1'b0, '0);
   endtask

   task automatic test_illegal();
      xfer(1'b1, 9'd291, 32'hFFFF_FFFF, '0, 1'b1, '0);
      xfer(1'b0, 9'd291, '0, '0, 1'b1, '0);
      xfer(1'b1, 9'd511, 32'h0000_000F, '0, 1'b1, '0);
      xfer(1'b0, 9'd511, '0, '0, 1'b1, '0);
      xfer(1'b0, A_CTRL, '0, 32'h0000_00AA, 1'b0, '0);
      xfer(1'b0, A_STAT, '0, 32'h0, 1'b0, '0);
      total++;
      if (COEFF_OUT !== model_coeff() || BANK_VLD !== '0) begin
         bad++;
         $display("FAIL illegal_side_effect got vld=%b want 0000 and banks=model", BANK_VLD);
      end
   endtask

   task automatic test_psel_drop();
      int hits;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_CTRL; PWDATA = 32'h55;
      @(posedge clk); #1;
      PSEL = 1'b0; PENABLE = 1'b1;
      hits = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (PREADY !== 1'b0) hits++;
      end
      PENABLE = 1'b0;
      total++;
      if (hits != 0) begin
         bad++;
         $display("FAIL psel_drop_ready got=%0d ready cycles want=0", hits);
      end
      total++;
      if (CTRL_EN !== 6'b101010 || OUT_SEL !== 2'b10) begin
         bad++;
         $display("FAIL psel_drop_write got en=%b sel=%b want 101010 10", CTRL_EN, OUT_SEL);
      end
      xfer(1'b0, A_CTRL, '0, 32'h0000_00AA, 1'b0, '0);
   endtask

   task automatic test_reset_mid();
      wr_coeff(9'd72, 32'h0000_0777);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_COMMIT; PWDATA = 32'hF;
      @(posedge clk); #1;
      PENABLE = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({PREADY, PSLVERR, PRDATA, BANK_VLD, CTRL_EN, OUT_SEL, IRQ} !== '0 ||
          COEFF_OUT !== '0) begin
         bad++;
         $display("FAIL reset_async got rdy=%b vld=%b en=%b sel=%b want all 0",
                  PREADY, BANK_VLD, CTRL_EN, OUT_SEL);
      end
      @(posedge clk); #1;
      total++;
      if (BANK_VLD !== '0 || PREADY !== 1'b0) begin
         bad++;
         $display("FAIL reset_no_commit got vld=%b rdy=%b want 0000 0", BANK_VLD, PREADY);
      end
      PSEL = 1'b0; PENABLE = 1'b0;
      rst_n = 1'b1;
      clear_model();
      @(posedge clk); #1;
      xfer(1'b0, A_COMMIT, '0, 32'h0, 1'b0, '0);
      xfer(1'b0, 9'd72, '0, 32'h0, 1'b0, '0);
      xfer(1'b0, 9'd5, '0, 32'h0, 1'b0, '0);
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_commit();
      test_ctrl();
      test_status();
      test_illegal();
      test_psel_drop();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apb_coeff_bank_regfile.md
Name: apb_coeff_bank_regfile

Overview:
- Parametrised APB-slave configuration register file that replaces the fixed-map coefficient RAM for the DFE filter array.
- Holds NUM_BANKS coefficient banks. Each bank is double-buffered: APB writes go to a shadow copy, and a commit copies the shadow to the active copy atomically, so filters never see a half-loaded coefficient set.
- Also holds a control register (channel enables, output select) and a sticky write-1-to-clear status register fed by the filter channels.
- Adds a real APB handshake with one wait state, and PSLVERR on out-of-range addresses.

Parameters:
- ADDR_WIDTH, 9: APB address width. Must satisfy NUM_BANKS*BANK_DEPTH+3 <= 2**ADDR_WIDTH.
- DATA_WIDTH, 32: APB data width.
- COEFF_WIDTH, 20: width of each coefficient. Must be <= DATA_WIDTH.
- NUM_BANKS, 4: number of coefficient banks.
- BANK_DEPTH, 72: coefficients per bank.
- NUM_CH, 6: filter channels (enable bits and status pairs).
- SEL_W, 2: OUT_SEL width. Must satisfy NUM_CH+SEL_W <= DATA_WIDTH and 2*NUM_CH <= DATA_WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_WIDTH  word address
- PWDATA  in  DATA_WIDTH  write data
- PREADY  out  1  transfer complete (registered)
- PRDATA  out  DATA_WIDTH  read data (registered)
- PSLVERR  out  1  address error, valid while PREADY=1
- COEFF_OUT  out  NUM_BANKS*BANK_DEPTH*COEFF_WIDTH  active coefficients, flattened; bank b word k at index (b*BANK_DEPTH+k)*COEFF_WIDTH
- BANK_VLD  out  NUM_BANKS  one-cycle pulse per committed bank
- CTRL_EN  out  NUM_CH  channel enables
- OUT_SEL  out  SEL_W  output block select
- STATUS_IN  in  2*NUM_CH  set pulses; bit 2c = overflow of channel c, bit 2c+1 = underflow
- IRQ  out  1  registered OR of all sticky status bits

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous, active-low.
  - Outputs: all outputs 0, including COEFF_OUT, BANK_VLD, CTRL_EN, OUT_SEL, PREADY, PRDATA, PSLVERR and IRQ.
  - Internal state: shadow banks, active banks, STATUS, LOADED bitmap and FSM all cleared; FSM returns to IDLE.
  - Reset mid-transfer aborts the transfer; no write takes effect.
- Address map (B = NUM_BANKS*BANK_DEPTH):
  - 0..B-1: shadow coefficients.
  - B: CTRL. Bits [NUM_CH-1:0] = CTRL_EN; bits [NUM_CH+SEL_W-1:NUM_CH] = OUT_SEL.
  - B+1: COMMIT. Write bit b = 1 commits bank b. Reads return the LOADED bitmap (banks committed at least once since reset).
  - B+2: STATUS. Read/W1C, 2*NUM_CH bits.
  - >= B+3: illegal.
- FSM states IDLE, ACCESS, DONE:
  - IDLE -> ACCESS when PSEL=1 and PENABLE=0 (setup phase).
  - ACCESS -> DONE when PSEL=1 and PENABLE=1, on the first access cycle. At this edge the write is performed, PRDATA and PSLVERR are registered, and PREADY is set to 1.
  - DONE -> IDLE unconditionally. PREADY, PRDATA and PSLVERR return to 0 at this edge.
  - ACCESS -> IDLE if PSEL drops (protocol violation); no write.
  - Net effect: exactly one wait state; PREADY is high for exactly one cycle per transfer.
- Coefficient write: stores PWDATA[COEFF_WIDTH-1:0].
- Coefficient read: returns the shadow value sign-extended to DATA_WIDTH.
- Unused bits of CTRL and STATUS read as 0.
- Commit:
  - At the DONE-entry edge, every bank with a set bit is copied shadow -> active in a single cycle.
  - The corresponding BANK_VLD bit and LOADED bit are set at that edge.
  - BANK_VLD clears the next cycle.
  - Multiple bits commit simultaneously.
  - Writing 0 to COMMIT has no effect.
- STATUS:
  - Each bit sets on a STATUS_IN pulse, then holds until cleared.
  - Cleared by a write of 1 to the same bit position.
  - Set and clear in the same cycle: set wins.
  - IRQ follows STATUS with one cycle of latency.
- Illegal address:
  - PSLVERR=1 with PREADY.
  - Writes are discarded.
  - PRDATA = 0.
- PREADY is never asserted outside DONE.

Test Plan:
- Reset values, then back-to-back transfers: write bank0 word5 = 0x000FFFFF, read it back -> PRDATA = 0xFFFFFFFF (sign-extended). PREADY is high exactly 2 cycles after setup; COEFF_OUT for bank0 is still 0.
- Commit: write 0x5 to COMMIT -> BANK_VLD = 4'b0101 for one cycle. Active banks 0 and 2 equal their shadows and banks 1 and 3 stay 0. Reading COMMIT -> 0x5.
- CTRL: write 0xAA (NUM_CH=6, SEL_W=2) -> CTRL_EN = 6'b101010, OUT_SEL = 2'b10. Read returns 0xAA.
- STATUS: pulse STATUS_IN bit 3 -> STATUS = 0x8 and IRQ = 1 one cycle later. Write 0x8 in the same cycle as a new bit-3 pulse -> bit stays set. A later write of 0x8 -> STATUS = 0, IRQ = 0.
- Address 291 (B+3) read and write -> PSLVERR = 1, PRDATA = 0, no state change. Dropping PSEL during the access phase -> no write, no PREADY.
- rst_n asserted during ACCESS of a COMMIT write -> no BANK_VLD pulse, all outputs 0 immediately.
